ram_b_ctrl: RTL and testbench

Request-side access controller sitting directly upstream of the RAM_B data memory. Accepts single-outstanding word requests over a valid/ready handshake. Drives the memory's `addra`/`dina`/`wea` and captures its 48-bit tagged read word. Range-checks addresses, validates the 16-bit tag, strips it, and returns a 32-bit response. Optionally performs byte-masked writes as read-modify-write.

---
 rtl/ram_b_pkg.sv | 33 +++
 rtl/ram_b_merge.sv | 16 +
 rtl/ram_b_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ram_b_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_b_pkg.sv
// Shared types and constants for the RAM_B request-side controller.
// The byte-merge helper is used by ram_b_merge (built with RAM_B_CTRL_RMW_EN).
package ram_b_pkg;

  localparam int unsigned RAM_B_DEPTH = 128;
  localparam logic [15:0] RAM_B_TAG   = 16'hFF37;
  localparam int unsigned ADDR_W      = 20;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TAG_W       = 16;
  localparam int unsigned BE_W        = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Request fields latched at acceptance for the read-modify-write flow.
  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } rmw_req_t;

  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/ram_b_merge.sv
// Combinational byte merge: enabled bytes from new_i, the rest from old_i.
module ram_b_merge
  import ram_b_pkg::*;
(
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] new_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] merged_o
);

  logic [DATA_W-1:0] mask;

  assign mask     = be_to_mask(be_i);
  assign merged_o = (new_i & mask) | (old_i & ~mask);

endmodule

// File: rtl/ram_b_ctrl.sv
// Single-outstanding request controller in front of the tagged RAM_B memory.
// Define RAM_B_CTRL_RMW_EN to build byte-masked writes as read-modify-write.
module ram_b_ctrl
  import ram_b_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_B_DEPTH,
  parameter logic [15:0] TAG   = RAM_B_TAG
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              wea,
  input  logic [47:0]       douta
);

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dina_q;
  logic              wea_q;

  logic accept;
  logic in_range;
  logic tag_ok;

  assign accept   = req_valid && req_ready_q;
  assign in_range = req_addr < ADDR_W'(DEPTH);
  assign tag_ok   = douta[47:32] == TAG;

`ifdef RAM_B_CTRL_RMW_EN
  rmw_req_t          rmw_q;
  logic              rmw_pend_q;
  logic [DATA_W-1:0] merged_d;

  ram_b_merge u_merge (
    .old_i    (douta[DATA_W-1:0]),
    .new_i    (rmw_q.wdata),
    .be_i     (rmw_q.be),
    .merged_o (merged_d)
  );
`else
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addra_q     <= '0;
      dina_q      <= '0;
      wea_q       <= 1'b0;
`ifdef RAM_B_CTRL_RMW_EN
      rmw_q       <= '0;
      rmw_pend_q  <= 1'b0;
`endif
    end else begin
      wea_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef RAM_B_CTRL_RMW_EN
            rmw_pend_q  <= 1'b0;
`endif
            // Out-of-range requests never touch the memory port.
            if (!in_range) begin
              rsp_err_q <= 1'b1;
              state_q   <= ST_RESP;
            end else if (!req_we) begin
              addra_q <= req_addr;
              state_q <= ST_READ;
            end
`ifdef RAM_B_CTRL_RMW_EN
            else if (req_be == '0) begin
              state_q <= ST_RESP;
            end else if (req_be != '1) begin
              addra_q    <= req_addr;
              rmw_q      <= '{wdata: req_wdata, be: req_be};
              rmw_pend_q <= 1'b1;
              state_q    <= ST_READ;
            end
`endif
            else begin
              addra_q <= req_addr;
              dina_q  <= req_wdata;
              wea_q   <= 1'b1;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_READ: state_q <= ST_WAIT;
        ST_WAIT: begin
`ifdef RAM_B_CTRL_RMW_EN
          if (rmw_pend_q) begin
            // A bad tag aborts the merge so a corrupt word is never rewritten.
            if (tag_ok) begin
              dina_q  <= merged_d;
              wea_q   <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end else
`endif
          begin
            rsp_rdata_q <= douta[DATA_W-1:0];
            rsp_err_q   <= !tag_ok;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // Paths that enter RESP straight from IDLE present the response one edge later.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign wea       = wea_q;

endmodule

// File: tb/tb_ram_b_ctrl.sv
// Bench for ram_b_ctrl: directed vector table, reset corner cases, and random
// traffic against a word-level memory model. Honours RAM_B_CTRL_RMW_EN.
module tb_ram_b_ctrl;

  localparam int          DEPTH = 128;
  localparam logic [15:0] TAG   = 16'hFF37;
  localparam int          NV    = 15;

  logic        clka = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [19:0] addra;
  logic [31:0] dina;
  logic        wea;
  logic [47:0] douta;
  logic        mem_load;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clka = ~clka;

  ram_b_ctrl #(.DEPTH(DEPTH), .TAG(TAG)) dut (
    .clka(clka), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addra(addra), .dina(dina), .wea(wea), .douta(douta)
  );

  function automatic logic [31:0] init_data(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic logic [15:0] init_tag(input int i);
    return (i == 32 || i == 33) ? 16'h0000 : TAG;
  endfunction

  // Tagged memory with registered read port; writes update data, keep the tag.
  logic [47:0] mem [DEPTH];
  always @(posedge clka) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {init_tag(i), init_data(i)};
    end else if (wea && addra < DEPTH) begin
      mem[addra[6:0]][31:0] <= dina;
    end
    douta <= (addra < DEPTH) ? mem[addra[6:0]] : 48'h0;
  end

  // Reference model: word array plus tag array, updated per request.
  logic [31:0] ref_mem [DEPTH];
  logic [15:0] ref_tag [DEPTH];

  task automatic model(input logic we, input logic [19:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] r, output logic e,
                       output int lat, output int nw, output logic [31:0] ww);
    int a;
    r = '0; e = 1'b0; lat = 1; nw = 0; ww = '0;
    if (addr >= DEPTH) begin e = 1'b1; return; end
    a = int'(addr);
    if (!we) begin
      r = ref_mem[a]; e = (ref_tag[a] != TAG); lat = 2;
      return;
    end
`ifdef RAM_B_CTRL_RMW_EN
    if (be == 4'h0) return;
    if (be != 4'hF) begin
      lat = 2;
      if (ref_tag[a] != TAG) begin e = 1'b1; return; end
      ww = ref_mem[a];
      for (int b = 0; b < 4; b++) if (be[b]) ww[8*b +: 8] = wd[8*b +: 8];
      lat = 3; nw = 1; ref_mem[a] = ww;
      return;
    end
`endif
    ww = wd; nw = 1; ref_mem[a] = wd;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency and wea pulses, hold the response, handshake.
  task automatic run_req(input logic we, input logic [19:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int hold,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nwea, output logic [31:0] wdina, output logic [19:0] waddr);
    int n;
    rd = '0; er = 1'b0; lat = -1; nwea = 0; wdina = '0; waddr = '0;
    @(negedge clka);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clka); n++; end
    if (n >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready stuck at 0");
      req_valid = 1'b0;
      return;
    end
    @(posedge clka); #1;
    req_valid = 1'b0; req_addr = 20'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
    for (n = 0; n <= 20; n++) begin
      if (n > 0) begin @(posedge clka); #1; end
      if (wea) begin nwea++; wdina = dina; waddr = addra; end
      if (rsp_valid) begin lat = n; break; end
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid never rose");
      return;
    end
    rd = rsp_rdata; er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clka); #1;
      if (wea) nwea++;
      chk("hold_stable", {rsp_valid, rsp_rdata, rsp_err, req_ready}, {1'b1, rd, er, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clka); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    if (!req_ready) begin @(posedge clka); #1; end
    chk("ready_back", req_ready, 1'b1);
  endtask

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wea;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, m_r, m_w, wdina;
    logic        er, m_e, we;
    logic [19:0] waddr, addr;
    logic [3:0]  be;
    int          lat, nw, m_lat, m_nw;

    vecs[0]  = '{1'b1, 20'h010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1, 1};
    vecs[1]  = '{1'b0, 20'h010, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0, 2, 0};
    vecs[4]  = '{1'b1, 20'h080, 32'h11111111, 4'hF, 0, 32'h0, 1'b1, 1, 0};
    vecs[5]  = '{1'b0, 20'h080, 32'h0,        4'hF, 0, 32'h0, 1'b1, 1, 0};
    vecs[6]  = '{1'b0, 20'h000, 32'h0,        4'hF, 0, 32'h10000000, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 20'h020, 32'h0,        4'hF, 0, 32'h10000020, 1'b1, 2, 0};
    vecs[14] = '{1'b0, 20'hFFFFF, 32'h0,      4'hF, 1, 32'h0, 1'b1, 1, 0};
`ifdef RAM_B_CTRL_RMW_EN
    vecs[2]  = '{1'b1, 20'h010, 32'h0000AA00, 4'b0010, 0, 32'h0, 1'b0, 3, 1};
    vecs[3]  = '{1'b0, 20'h010, 32'h0,        4'hF, 5, 32'hDEADAAEF, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 20'h011, 32'hCAFEF00D, 4'h0, 0, 32'h0, 1'b0, 1, 0};
    vecs[8]  = '{1'b0, 20'h011, 32'h0,        4'hF, 0, 32'h10000011, 1'b0, 2, 0};
    vecs[9]  = '{1'b1, 20'h012, 32'h12345678, 4'b0010, 2, 32'h0, 1'b0, 3, 1};
    vecs[10] = '{1'b0, 20'h012, 32'h0,        4'hF, 0, 32'h10005612, 1'b0, 2, 0};
    vecs[12] = '{1'b1, 20'h020, 32'hABCDEF01, 4'b0001, 0, 32'h0, 1'b1, 2, 0};
    vecs[13] = '{1'b0, 20'h020, 32'h0,        4'hF, 0, 32'h10000020, 1'b1, 2, 0};
`else
    vecs[2]  = '{1'b1, 20'h010, 32'h0000AA00, 4'b0010, 0, 32'h0, 1'b0, 1, 1};
    vecs[3]  = '{1'b0, 20'h010, 32'h0,        4'hF, 5, 32'h0000AA00, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 20'h011, 32'hCAFEF00D, 4'h0, 0, 32'h0, 1'b0, 1, 1};
    vecs[8]  = '{1'b0, 20'h011, 32'h0,        4'hF, 0, 32'hCAFEF00D, 1'b0, 2, 0};
    vecs[9]  = '{1'b1, 20'h012, 32'h12345678, 4'b0010, 2, 32'h0, 1'b0, 1, 1};
    vecs[10] = '{1'b0, 20'h012, 32'h0,        4'hF, 0, 32'h12345678, 1'b0, 2, 0};
    vecs[12] = '{1'b1, 20'h020, 32'hABCDEF01, 4'b0001, 0, 32'h0, 1'b0, 1, 1};
    vecs[13] = '{1'b0, 20'h020, 32'h0,        4'hF, 0, 32'hABCDEF01, 1'b1, 2, 0};
`endif

    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = init_data(i); ref_tag[i] = init_tag(i); end

    rst_n = 1'b0; mem_load = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clka);
    #1 mem_load = 1'b0;
    chk("rst_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, addra, dina, wea}, '0);
    @(negedge clka) rst_n = 1'b1;
    #1 chk("rst_ready_low", req_ready, 1'b0);
    @(posedge clka); #1;
    chk("rst_ready_rise", req_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold,
              rd, er, lat, nw, wdina, waddr);
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, m_r, m_e, m_lat, m_nw, m_w);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), er, vecs[i].exp_err);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_wea", i), 64'(nw), 64'(vecs[i].exp_wea));
      if (vecs[i].exp_wea > 0)
        chk($sformatf("v%0d_wport", i), {waddr, wdina}, {vecs[i].addr, m_w});
    end
    chk("word0_intact", mem[0], {TAG, 32'h10000000});

    // Reset while the request for 0x010 sits in WAIT.
    @(negedge clka);
    req_valid = 1'b1; req_addr = 20'h010; req_wdata = 32'hFFFFFFFF; req_be = 4'b0001;
`ifdef RAM_B_CTRL_RMW_EN
    req_we = 1'b1;
`else
    req_we = 1'b0;
`endif
    chk("rr_ready", req_ready, 1'b1);
    @(posedge clka); #1;
    req_valid = 1'b0;
    chk("rr_read_wea", wea, 1'b0);
    @(posedge clka); #1;
    rst_n = 1'b0;
    #1 chk("rr_async", {wea, req_ready, rsp_valid}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clka); #1;
      chk("rr_held", {wea, req_ready, rsp_valid}, 3'b000);
    end
    @(negedge clka) rst_n = 1'b1;
    @(posedge clka); #1;
    chk("rr_release", {req_ready, rsp_valid, wea}, 3'b100);
    run_req(1'b0, 20'h010, 32'h0, 4'hF, 0, rd, er, lat, nw, wdina, waddr);
    model(1'b0, 20'h010, 32'h0, 4'hF, m_r, m_e, m_lat, m_nw, m_w);
    chk("rr_old_value", {rd, er}, {m_r, m_e});

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      we   = 1'($urandom);
      be   = 4'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 20'($urandom_range(128, 20'hFFFFF))
                                         : 20'($urandom_range(0, 63));
      run_req(we, addr, $urandom, be, $urandom_range(0, 2), rd, er, lat, nw, wdina, waddr);
      model(we, addr, req_wdata_last(), be, m_r, m_e, m_lat, m_nw, m_w);
      chk($sformatf("r%0d_rsp", i), {rd, er}, {m_r, m_e});
      chk($sformatf("r%0d_lat_wea", i), {32'(lat), 32'(nw)}, {32'(m_lat), 32'(m_nw)});
      if (m_nw > 0) chk($sformatf("r%0d_wport", i), {waddr, wdina}, {addr, m_w});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // The random loop passes $urandom straight into run_req; capture the value
  // the DUT actually saw at acceptance so the model uses the same data.
  logic [31:0] last_wdata;
  always @(posedge clka) if (req_valid && req_ready) last_wdata <= req_wdata;

  function automatic logic [31:0] req_wdata_last();
    return last_wdata;
  endfunction

endmodule
